// File: rtl/fetch_sequencer_if.sv
// Bus between the run-control sequencer and its environment: the instruction
// ROM address, decoder fields, the Start/Done handshake and the counters.
//
// Handshake: Start is a level sampled only while the sequencer is in IDLE or
// HALTED. It loads StartAddr and clears the counters on that clock edge and is
// ignored everywhere else. Done is high exactly while the sequencer sits in
// HALTED, so it drops on the cycle after a Start is accepted. InstValid is the
// per-cycle commit strobe for the instruction at ProgCounter.
interface fetch_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 5,
  parameter int CNT_W = 16
);
  logic             Start;
  logic [PC_W-1:0]  StartAddr;
  logic             HALT;
  logic             Branch;
  logic             Zero;
  logic [OFF_W-1:0] BrOffset;
  logic             MemAccess;
  logic [PC_W-1:0]  ProgCounter;
  logic             InstValid;
  logic             Done;
  logic [CNT_W-1:0] CycleCount;
  logic [CNT_W-1:0] InstCount;

  // Environment side: drives control and decoder fields, observes status.
  modport master (
    output Start, StartAddr, HALT, Branch, Zero, BrOffset, MemAccess,
    input  ProgCounter, InstValid, Done, CycleCount, InstCount
  );

  // Sequencer side.
  modport slave (
    input  Start, StartAddr, HALT, Branch, Zero, BrOffset, MemAccess,
    output ProgCounter, InstValid, Done, CycleCount, InstCount
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Run-control sequencer for the accumulator processor: owns the program
// counter, inserts fixed wait cycles for load/store, emits the commit strobe
// and keeps saturating cycle/instruction counters.
module fetch_sequencer #(
  parameter int PC_W    = 10,
  parameter int OFF_W   = 5,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                CLK,
  input  logic                reset,
  fetch_sequencer_if.slave    bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  // Wait counter only needs to hold MEM_LAT-1; keep at least one bit so the
  // MEM_LAT=0 build still elaborates (the counter is then never loaded).
  localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam bit HAS_WAIT = (MEM_LAT > 0);
  localparam logic [WAIT_W-1:0] WAIT_INIT = (MEM_LAT > 0) ? WAIT_W'(MEM_LAT - 1) : '0;
  localparam logic [WAIT_W-1:0] WAIT_ONE  = 1;
  localparam logic [PC_W-1:0]   PC_ONE    = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_cyc_cnt;
  logic [CNT_W-1:0]  r_inst_cnt;

  logic              w_commit;
  logic              w_mem_enter;
  logic              w_load;
  logic              w_cnt_en;
  logic              w_done;
  logic [PC_W-1:0]   w_off_ext;
  logic [PC_W-1:0]   w_next_pc;

  // Branch target: sign-extended displacement, wraps modulo 2^PC_W.
  assign w_off_ext = {{(PC_W-OFF_W){bus.BrOffset[OFF_W-1]}}, bus.BrOffset};
  assign w_next_pc = (bus.Branch && bus.Zero) ? (r_pc + w_off_ext) : (r_pc + PC_ONE);

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; HALT outranks MemAccess in RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_HALTED: if (bus.Start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.HALT)                       w_state_nxt = S_HALTED;
        else if (bus.MemAccess && HAS_WAIT) w_state_nxt = S_MEMWAIT;
      end
      S_MEMWAIT: if (r_wait == '0) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode from state and current decoder inputs.
  always_comb begin
    w_commit    = 1'b0;
    w_mem_enter = 1'b0;
    w_load      = 1'b0;
    w_cnt_en    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: w_load = bus.Start;
      S_RUN: begin
        w_cnt_en = 1'b1;
        if (!bus.HALT) begin
          if (bus.MemAccess && HAS_WAIT) w_mem_enter = 1'b1;
          else                           w_commit    = 1'b1;
        end
      end
      S_MEMWAIT: begin
        w_cnt_en = 1'b1;
        w_commit = (r_wait == '0);
      end
      S_HALTED: begin
        w_done = 1'b1;
        w_load = bus.Start;
      end
      default: ;
    endcase
  end

  // PC, wait counter and saturating performance counters.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_pc       <= '0;
      r_wait     <= '0;
      r_cyc_cnt  <= '0;
      r_inst_cnt <= '0;
    end else if (w_load) begin
      r_pc       <= bus.StartAddr;
      r_cyc_cnt  <= '0;
      r_inst_cnt <= '0;
    end else begin
      if (w_commit) begin
        r_pc <= w_next_pc;
        if (r_inst_cnt != CNT_MAX) r_inst_cnt <= r_inst_cnt + CNT_ONE;
      end
      if (w_cnt_en && (r_cyc_cnt != CNT_MAX)) r_cyc_cnt <= r_cyc_cnt + CNT_ONE;
      if (w_mem_enter)                                     r_wait <= WAIT_INIT;
      else if ((r_state == S_MEMWAIT) && (r_wait != '0))   r_wait <= r_wait - WAIT_ONE;
    end
  end

  assign bus.ProgCounter = r_pc;
  assign bus.InstValid   = w_commit;
  assign bus.Done        = w_done;
  assign bus.CycleCount  = r_cyc_cnt;
  assign bus.InstCount   = r_inst_cnt;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected commit PCs go into a queue when
// an instruction is issued and a monitor pops them on every InstValid pulse.
module tb_fetch_sequencer;

  localparam int PC_W    = 10;
  localparam int MEM_LAT = 2;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg;
  logic [1:0] dbg4;

  int n_cmp = 0;
  int n_err = 0;

  logic [PC_W-1:0] exp_q[$];
  logic [PC_W-1:0] mon_exp;

  fetch_sequencer_if #(.PC_W(10), .OFF_W(5), .CNT_W(16)) bus ();
  fetch_sequencer_if #(.PC_W(10), .OFF_W(5), .CNT_W(4))  b4 ();

  fetch_sequencer #(.PC_W(10), .OFF_W(5), .MEM_LAT(MEM_LAT), .CNT_W(16)) u_dut (
    .CLK(CLK), .reset(reset), .bus(bus), .o_dbg_state(dbg)
  );

  fetch_sequencer #(.PC_W(10), .OFF_W(5), .MEM_LAT(MEM_LAT), .CNT_W(4)) u_dut4 (
    .CLK(CLK), .reset(reset), .bus(b4), .o_dbg_state(dbg4)
  );

  // Clock / reset block
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_inputs();
    bus.HALT = 1'b0; bus.Branch = 1'b0; bus.Zero = 1'b0;
    bus.BrOffset = '0; bus.MemAccess = 1'b0;
  endtask

  // Driver: one instruction at the expected pc, held for its full latency.
  task automatic op(input logic [PC_W-1:0] pc, input logic h, input logic b,
                    input logic z, input logic [4:0] off, input logic m);
    bus.HALT = h; bus.Branch = b; bus.Zero = z; bus.BrOffset = off; bus.MemAccess = m;
    if (!h) exp_q.push_back(pc);
    #1;
    chk("pc_at_issue", 32'(bus.ProgCounter), 32'(pc));
    repeat ((m && !h) ? MEM_LAT + 1 : 1) tick();
    clr_inputs();
  endtask

  task automatic start(input logic [PC_W-1:0] addr);
    bus.Start = 1'b1; bus.StartAddr = addr;
    tick();
    bus.Start = 1'b0;
    clr_inputs();
  endtask

  // Scoreboard monitor: every commit must match the head of the queue.
  task automatic monitor();
    forever begin
      @(negedge CLK);
      if (!reset && bus.InstValid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL commit_pc: unexpected commit at pc %0h, none expected", bus.ProgCounter);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.ProgCounter !== mon_exp) begin
            n_err++;
            $display("FAIL commit_pc: got %0h expected %0h", bus.ProgCounter, mon_exp);
          end
        end
      end
    end
  endtask

  initial begin
    bus.Start = 1'b0; bus.StartAddr = '0; clr_inputs();
    b4.Start = 1'b0; b4.StartAddr = '0; b4.HALT = 1'b0; b4.Branch = 1'b0;
    b4.Zero = 1'b0; b4.BrOffset = '0; b4.MemAccess = 1'b0;
    fork monitor(); join_none

    // Reset state
    repeat (2) tick();
    chk("rst_state", 32'(dbg), 0);
    chk("rst_pc", 32'(bus.ProgCounter), 0);
    chk("rst_valid", 32'(bus.InstValid), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_cyc", 32'(bus.CycleCount), 0);
    chk("rst_inst", 32'(bus.InstCount), 0);
    reset = 1'b0;

    // Three plain ops from 0x010, then HALT
    start(10'h010);
    op(10'h010, 0, 0, 0, 5'd0, 0);
    op(10'h011, 0, 0, 0, 5'd0, 0);
    op(10'h012, 0, 0, 0, 5'd0, 0);
    op(10'h013, 1, 0, 0, 5'd0, 0);
    #1;
    chk("t1_done", 32'(bus.Done), 1);
    chk("t1_pc", 32'(bus.ProgCounter), 32'h013);
    chk("t1_inst", 32'(bus.InstCount), 3);
    chk("t1_cyc", 32'(bus.CycleCount), 4);
    chk("t1_q_empty", 32'(exp_q.size()), 0);

    // Load at 0x005: two dead cycles, commit on the third
    start(10'h005);
    chk("t2_done_drop", 32'(bus.Done), 0);
    bus.MemAccess = 1'b1;
    exp_q.push_back(10'h005);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_pc_hold", 32'(bus.ProgCounter), 32'h005);
      chk("t2_valid", 32'(bus.InstValid), (k == 2) ? 1 : 0);
      tick();
    end
    bus.MemAccess = 1'b0;
    #1;
    chk("t2_pc_next", 32'(bus.ProgCounter), 32'h006);
    chk("t2_inst", 32'(bus.InstCount), 1);
    chk("t2_cyc", 32'(bus.CycleCount), 3);
    op(10'h006, 1, 0, 0, 5'd0, 0);

    // Branches: backward, forward, not-taken, Zero alone, wrap both ways
    start(10'h020);
    op(10'h020, 0, 1, 1, 5'b11100, 0);
    op(10'h01C, 0, 1, 1, 5'd4, 0);
    op(10'h020, 0, 1, 0, 5'b11100, 0);
    op(10'h021, 0, 0, 1, 5'b11100, 0);
    op(10'h022, 1, 0, 0, 5'd0, 0);
    start(10'h3FF);
    op(10'h3FF, 0, 1, 1, 5'd1, 0);
    op(10'h000, 0, 1, 1, 5'b11111, 0);
    op(10'h3FF, 0, 0, 0, 5'd0, 0);
    op(10'h000, 1, 0, 0, 5'd0, 0);
    #1;
    chk("t3_pc_wrap", 32'(bus.ProgCounter), 32'h000);
    chk("t3_inst", 32'(bus.InstCount), 3);

    // HALT with MemAccess and Branch as first instruction
    start(10'h040);
    op(10'h040, 1, 1, 1, 5'd1, 1);
    #1;
    chk("t4_state", 32'(dbg), 3);
    chk("t4_done", 32'(bus.Done), 1);
    chk("t4_pc", 32'(bus.ProgCounter), 32'h040);
    chk("t4_inst", 32'(bus.InstCount), 0);
    chk("t4_cyc", 32'(bus.CycleCount), 1);

    // Restart from HALTED with Start held through RUN
    bus.Start = 1'b1; bus.StartAddr = 10'h100;
    #1;
    chk("t6_done_before", 32'(bus.Done), 1);
    tick();
    bus.StartAddr = 10'h200;
    #1;
    chk("t6_done", 32'(bus.Done), 0);
    chk("t6_pc", 32'(bus.ProgCounter), 32'h100);
    chk("t6_inst", 32'(bus.InstCount), 0);
    chk("t6_cyc", 32'(bus.CycleCount), 0);
    op(10'h100, 0, 0, 0, 5'd0, 0);
    op(10'h101, 0, 0, 0, 5'd0, 0);
    bus.Start = 1'b0;

    // Reset in the middle of MEMWAIT
    bus.MemAccess = 1'b1;
    #1;
    chk("t5_pc", 32'(bus.ProgCounter), 32'h102);
    chk("t5_valid_run", 32'(bus.InstValid), 0);
    tick();
    #1;
    chk("t5_state_wait", 32'(dbg), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clr_inputs();
    #1;
    chk("t5_state", 32'(dbg), 0);
    chk("t5_pc_rst", 32'(bus.ProgCounter), 0);
    chk("t5_cyc", 32'(bus.CycleCount), 0);
    chk("t5_inst", 32'(bus.InstCount), 0);
    chk("t5_valid", 32'(bus.InstValid), 0);
    chk("t5_done", 32'(bus.Done), 0);
    repeat (2) tick();
    chk("t5_idle_hold", 32'(dbg), 0);
    chk("t5_q_empty", 32'(exp_q.size()), 0);

    // Saturation on the CNT_W=4 instance: 20 plain instructions
    chk("sat_rst_inst", 32'(b4.InstCount), 0);
    b4.Start = 1'b1; b4.StartAddr = 10'h000;
    tick();
    b4.Start = 1'b0;
    repeat (20) tick();
    #1;
    chk("sat_inst", 32'(b4.InstCount), 15);
    chk("sat_cyc", 32'(b4.CycleCount), 15);
    chk("sat_pc", 32'(b4.ProgCounter), 32'h014);
    b4.HALT = 1'b1;
    tick();
    b4.HALT = 1'b0;
    #1;
    chk("sat_done", 32'(b4.Done), 1);
    chk("sat_inst_hold", 32'(b4.InstCount), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
